axi2mem_burst_sched: RTL and testbench
======================================

Name: axi2mem_burst_sched

Overview:
Sequencer in front of the AXI-to-TCDM bridge datapath.
- Accepts read and write burst commands from the AXI front-end.
- Arbitrates between them and expands the winning burst into per-beat requests for the multi-port TCDM datapath.
- Tracks outstanding beats and reports busy to the cluster.
- Never mixes read and write beats in flight.

Parameters:
NB_PORTS, 4, TCDM 32-bit ports per beat; beat address stride = NB_PORTS*4 bytes
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 8, burst length field width (AXI len: beats-1)
MAX_OUTSTANDING, 4, max issued-but-uncompleted beats (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_cmd_valid_i  in  1  read burst command valid
rd_cmd_ready_o  out  1  read command accepted
rd_cmd_addr_i  in  ADDR_WIDTH  read start byte address
rd_cmd_len_i  in  LEN_WIDTH  read beats-1
wr_cmd_valid_i  in  1  write burst command valid
wr_cmd_ready_o  out  1  write command accepted
wr_cmd_addr_i  in  ADDR_WIDTH  write start byte address
wr_cmd_len_i  in  LEN_WIDTH  write beats-1
beat_valid_o  out  1  beat request to datapath
beat_ready_i  in  1  datapath accepts beat (all ports granted)
beat_addr_o  out  ADDR_WIDTH  beat byte address
beat_we_o  out  1  1=write beat, 0=read beat
beat_last_o  out  1  final beat of burst
beat_done_i  in  1  one beat completed (read: all r_valid seen; write: all gnt seen)
busy_o  out  1  block active
err_o  out  1  sticky: beat_done_i while outstanding==0

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; round-robin pointer favours read.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - Arbitrates the valid commands; exactly one ready asserted, combinationally, in the same cycle as its valid.
  - On handshake: latch addr, len and direction; beats_left = len; go to ISSUE next cycle.
  - Commands are accepted only in IDLE.
- Arbitration:
  - Single requester wins.
  - Both valid: round-robin, the loser of the last contested cycle wins. The pointer updates only on a contested handshake.
- ISSUE:
  - beat_valid_o = 1 while outstanding < MAX_OUTSTANDING.
  - On beat_valid_o && beat_ready_i: addr += NB_PORTS*4, modulo 2^ADDR_WIDTH (silent wrap); beats_left decrements.
  - beat_last_o = (beats_left==0).
  - Last beat handshake -> DRAIN.
  - Outputs are registered-stable while valid && !ready.
- DRAIN: wait for outstanding==0, then IDLE. This is the turnaround guard between directions.
- Outstanding counter:
  - +1 on beat handshake, -1 on beat_done_i; both in the same cycle -> unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - beat_done_i at 0: counter stays 0, err_o set (cleared only by reset).
- busy_o = (state!=IDLE) || (outstanding!=0), registered (1-cycle lag allowed).
- Latency:
  - Command handshake to first beat_valid_o: 1 cycle.
  - len=0 burst: one beat with beat_last_o=1.
- Reset mid-burst: immediate return to IDLE, counters cleared, beat_valid_o drops asynchronously. Remaining beats are abandoned.

Optional Feature:
Macro AXI2MEM_SCHED_WR_PRIO_EN.
- Defined: contested IDLE cycles always grant write (fixed priority), which drains write buffers first. The round-robin pointer is not implemented.
- Undefined: round-robin as above.
- Single-requester behaviour is identical in both cases.

Decomposition:
- Package axi2mem_sched_pkg:
  - state enum (IDLE, ISSUE, DRAIN)
  - direction enum (DIR_RD, DIR_WR)
  - localparam function for beat stride
- Sub-module axi2mem_rr_arb2: 2-input round-robin arbiter with pointer register, handshake-qualified update, and the ifdef for fixed priority.

Test Plan:
- Read burst addr=0x100, len=3, beat_ready_i=1, done 2 cycles after each beat -> addrs 0x100, 0x110, 0x120, 0x130; last on 4th; busy_o falls after 4th done.
- Read and write valid together, twice, round-robin build -> read granted first, write second; no write beat until read outstanding==0.
- MAX_OUTSTANDING=4, len=7, beat_done_i held low -> exactly 4 beats issued, beat_valid_o low; one done pulse -> 5th beat next cycle.
- addr=0xFFFF_FFF0, len=1 -> beats at 0xFFFF_FFF0, 0x0000_0000; no error.
- beat_done_i pulse in IDLE -> err_o=1 sticky, outstanding stays 0; rst_ni low during ISSUE -> all outputs 0 immediately, IDLE after release.
- AXI2MEM_SCHED_WR_PRIO_EN defined, both valid for 3 consecutive commands -> write granted every time.

Source files
------------

// File: rtl/axi2mem_sched_pkg.sv
// Shared types and helpers for the AXI-to-TCDM burst sequencer.
package axi2mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    // One beat covers every 32-bit TCDM port once.
    function automatic int unsigned beat_stride(input int unsigned nb_ports);
        return nb_ports * 4;
    endfunction

endpackage

// File: rtl/axi2mem_rr_arb2.sv
// Two-way read/write command arbiter (req/gnt bit 0 = read, bit 1 = write).
// AXI2MEM_SCHED_WR_PRIO_EN selects fixed write priority instead of round-robin.
module axi2mem_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef AXI2MEM_SCHED_WR_PRIO_EN
    logic w_unused;
    assign w_unused = clk_i ^ rst_ni;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
        end
    end
`else
    logic r_ptr_wr;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&req_i) begin
                gnt_o = r_ptr_wr ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // A grant is always taken, so a contested enabled cycle is a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr_wr <= 1'b0;
        end else if (en_i && (&req_i)) begin
            r_ptr_wr <= ~r_ptr_wr;
        end
    end
`endif

endmodule

// File: rtl/axi2mem_burst_sched.sv
// Burst sequencer: arbitrates read/write commands and expands them into beats.
// Optional AXI2MEM_SCHED_WR_PRIO_EN gives writes fixed priority on contention.
module axi2mem_burst_sched
    import axi2mem_sched_pkg::*;
#(
    parameter int unsigned NB_PORTS        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_cmd_valid_i,
    output logic                  rd_cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  rd_cmd_len_i,
    input  logic                  wr_cmd_valid_i,
    output logic                  wr_cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  wr_cmd_len_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic                  beat_we_o,
    output logic                  beat_last_o,
    input  logic                  beat_done_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE =
        ADDR_WIDTH'(beat_stride(NB_PORTS));
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

    state_e                r_state;
    dir_e                  r_dir;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_left;
    logic [CW-1:0]         r_out;
    logic                  r_busy;
    logic                  r_err;

    logic [1:0] w_gnt;
    logic       w_idle;
    logic       w_issue;
    logic       w_beat_hs;
    logic       w_done_ok;

    assign w_idle  = (r_state == IDLE);
    assign w_issue = (r_state == ISSUE);

    axi2mem_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_idle),
        .req_i  ({wr_cmd_valid_i, rd_cmd_valid_i}),
        .gnt_o  (w_gnt)
    );

    assign rd_cmd_ready_o = w_gnt[0];
    assign wr_cmd_ready_o = w_gnt[1];

    assign beat_valid_o = w_issue && (r_out < MAX_OUT);
    assign w_beat_hs    = beat_valid_o && beat_ready_i;
    assign w_done_ok    = beat_done_i && (r_out != '0);

    assign beat_addr_o = r_addr;
    assign beat_we_o   = (r_dir == DIR_WR);
    assign beat_last_o = w_issue && (r_left == '0);
    assign busy_o      = r_busy;
    assign err_o       = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_dir   <= DIR_RD;
            r_addr  <= '0;
            r_left  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= !w_idle || (r_out != '0);
            if (beat_done_i && (r_out == '0)) begin
                r_err <= 1'b1;
            end
            if (w_beat_hs && !w_done_ok) begin
                r_out <= r_out + 1'b1;
            end else if (!w_beat_hs && w_done_ok) begin
                r_out <= r_out - 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_gnt[1]) begin
                        r_state <= ISSUE;
                        r_dir   <= DIR_WR;
                        r_addr  <= wr_cmd_addr_i;
                        r_left  <= wr_cmd_len_i;
                    end else if (w_gnt[0]) begin
                        r_state <= ISSUE;
                        r_dir   <= DIR_RD;
                        r_addr  <= rd_cmd_addr_i;
                        r_left  <= rd_cmd_len_i;
                    end
                end
                ISSUE: begin
                    if (w_beat_hs) begin
                        r_addr <= r_addr + STRIDE;
                        if (r_left == '0) begin
                            r_state <= DRAIN;
                        end else begin
                            r_left <= r_left - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Direction turnaround waits for every beat to retire.
                    if (r_out == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2mem_burst_sched.sv
// Directed + randomized bench for axi2mem_burst_sched with a beat-list model.
module tb_axi2mem_burst_sched;

    localparam int NBP  = 4;
    localparam int AW   = 32;
    localparam int LW   = 8;
    localparam int MAXO = 4;
    localparam logic [31:0] STRIDE = 32'(NBP * 4);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_cmd_valid_i = 1'b0;
    logic          rd_cmd_ready_o;
    logic [AW-1:0] rd_cmd_addr_i = '0;
    logic [LW-1:0] rd_cmd_len_i = '0;
    logic          wr_cmd_valid_i = 1'b0;
    logic          wr_cmd_ready_o;
    logic [AW-1:0] wr_cmd_addr_i = '0;
    logic [LW-1:0] wr_cmd_len_i = '0;
    logic          beat_valid_o;
    logic          beat_ready_i = 1'b0;
    logic [AW-1:0] beat_addr_o;
    logic          beat_we_o;
    logic          beat_last_o;
    logic          beat_done_i = 1'b0;
    logic          busy_o;
    logic          err_o;

    int errors = 0;
    int checks = 0;
    bit m_ptr_wr = 1'b0;
    bit m_err = 1'b0;

    axi2mem_burst_sched #(
        .NB_PORTS(NBP),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .rd_cmd_valid_i(rd_cmd_valid_i),
        .rd_cmd_ready_o(rd_cmd_ready_o),
        .rd_cmd_addr_i(rd_cmd_addr_i),
        .rd_cmd_len_i(rd_cmd_len_i),
        .wr_cmd_valid_i(wr_cmd_valid_i),
        .wr_cmd_ready_o(wr_cmd_ready_o),
        .wr_cmd_addr_i(wr_cmd_addr_i),
        .wr_cmd_len_i(wr_cmd_len_i),
        .beat_valid_o(beat_valid_o),
        .beat_ready_i(beat_ready_i),
        .beat_addr_o(beat_addr_o),
        .beat_we_o(beat_we_o),
        .beat_last_o(beat_last_o),
        .beat_done_i(beat_done_i),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, beat_valid_o, 0);
        chk({tag, "_last"}, beat_last_o, 0);
        chk({tag, "_rdy"}, {rd_cmd_ready_o, wr_cmd_ready_o}, 0);
    endtask

    task automatic issue(input bit rv, input logic [31:0] ra, input int rl,
                         input bit wv, input logic [31:0] wa, input int wl,
                         output bit won_wr);
        bit exp_wr;
        @(negedge clk);
        rd_cmd_valid_i = rv;
        rd_cmd_addr_i  = ra;
        rd_cmd_len_i   = LW'(rl);
        wr_cmd_valid_i = wv;
        wr_cmd_addr_i  = wa;
        wr_cmd_len_i   = LW'(wl);
        #1;
`ifdef AXI2MEM_SCHED_WR_PRIO_EN
        exp_wr = wv;
`else
        exp_wr = (rv && wv) ? m_ptr_wr : wv;
`endif
        chk("rd_cmd_ready", rd_cmd_ready_o, !exp_wr);
        chk("wr_cmd_ready", wr_cmd_ready_o, exp_wr);
        if (rv && wv) m_ptr_wr = !exp_wr;
        won_wr = exp_wr;
        @(posedge clk);
        #1;
        if (exp_wr) wr_cmd_valid_i = 1'b0;
        else rd_cmd_valid_i = 1'b0;
    endtask

    task automatic body(input bit we, input logic [31:0] start, input int len,
                        input int rdy_pct, input int done_pct, input int hold);
        int idx = 0;
        int outs = 0;
        int cyc = 0;
        int n = 0;
        bit ev;
        bit rdy;
        bit dn;
        logic [31:0] ea;
        while ((idx <= len || outs > 0) && cyc < 400) begin
            @(negedge clk);
            rdy = ($urandom_range(99) < rdy_pct);
            dn = (cyc >= hold) && (outs > 0) && ($urandom_range(99) < done_pct);
            beat_ready_i = rdy;
            beat_done_i = dn;
            #1;
            ev = (idx <= len) && (outs < MAXO);
            chk("beat_valid", beat_valid_o, ev);
            if (ev) begin
                ea = start + STRIDE * 32'(idx);
                chk("beat_addr", beat_addr_o, ea);
                chk("beat_we", beat_we_o, we);
                chk("beat_last", beat_last_o, idx == len);
            end
            chk("cmd_ready_in_burst", {rd_cmd_ready_o, wr_cmd_ready_o}, 0);
            if (cyc > 0) chk("busy_active", busy_o, 1);
            @(posedge clk);
            if (ev && rdy) begin
                idx++;
                outs++;
            end
            if (dn) outs--;
            cyc++;
        end
        chk("beats_issued", idx, len + 1);
        chk("beats_retired", outs, 0);
        @(negedge clk);
        beat_ready_i = 1'b0;
        beat_done_i = 1'b0;
        rd_cmd_valid_i = 1'b0;
        wr_cmd_valid_i = 1'b0;
        while (busy_o !== 1'b0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall", busy_o, 0);
        chk("err_state", err_o, m_err);
    endtask

    task automatic contest(input logic [31:0] ra, input int rl,
                           input logic [31:0] wa, input int wl);
        bit w;
        bit w2;
        issue(1'b1, ra, rl, 1'b1, wa, wl, w);
        body(w, w ? wa : ra, w ? wl : rl, 100, 70, 0);
        issue(w ? 1'b1 : 1'b0, ra, rl, w ? 1'b0 : 1'b1, wa, wl, w2);
        chk("loser_dir", w2, !w);
        body(w2, w2 ? wa : ra, w2 ? wl : rl, 80, 60, 0);
    endtask

    initial begin
        bit w;
        logic [31:0] a;
        int l;

        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", beat_addr_o, 0);
        chk("rst_we", beat_we_o, 0);
        chk_quiet("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 32'h100, 3, 1'b0, 32'h0, 0, w);
        body(1'b0, 32'h100, 3, 100, 100, 0);

        contest(32'h2000, 2, 32'h3000, 1);
        contest(32'h4000, 1, 32'h5000, 3);
        contest(32'h6000, 0, 32'h7000, 0);

        issue(1'b1, 32'h800, 7, 1'b0, 32'h0, 0, w);
        body(1'b0, 32'h800, 7, 100, 60, 10);

        issue(1'b0, 32'h0, 0, 1'b1, 32'hFFFF_FFF0, 1, w);
        body(1'b1, 32'hFFFF_FFF0, 1, 100, 80, 0);

        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            l = $urandom_range(6);
            issue(k[0], a, l, !k[0], a, l, w);
            body(w, a, l, $urandom_range(100, 30), $urandom_range(90, 30), 0);
        end

        @(negedge clk);
        beat_done_i = 1'b1;
        @(negedge clk);
        beat_done_i = 1'b0;
        m_err = 1'b1;
        #1;
        chk("err_set", err_o, 1);
        chk_quiet("err_idle");
        repeat (3) @(negedge clk);
        chk("err_sticky", err_o, 1);
        chk("err_busy", busy_o, 0);

        issue(1'b0, 32'h0, 0, 1'b1, 32'h9000, 5, w);
        body(1'b1, 32'h9000, 5, 100, 50, 6);

        issue(1'b1, 32'hA000, 10, 1'b0, 32'h0, 0, w);
        @(negedge clk);
        beat_ready_i = 1'b1;
        @(negedge clk);
        #2;
        chk("pre_rst_valid", beat_valid_o, 1);
        rst_n = 1'b0;
        #1;
        beat_ready_i = 1'b0;
        m_err = 1'b0;
        m_ptr_wr = 1'b0;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_addr", beat_addr_o, 0);
        chk("mid_rst_we", beat_we_o, 0);
        chk_quiet("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        contest(32'hB000, 2, 32'hC000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
